// File: rtl/neuron_pkg.sv
// Shared types, default geometry and the rescale/saturate helper for the neuron datapath stages.
package neuron_pkg;

    localparam int unsigned N_DEF = 16;
    localparam int unsigned F_DEF = 8;
    localparam int unsigned Q_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic               sat;
        logic signed [31:0] val;
    } sat_res_t;

    // Floor-rounding arithmetic shift by f, then clamp to the signed n-bit range (n <= 32).
    function automatic sat_res_t sat_shift(input logic signed [63:0] acc,
                                           input int unsigned        f,
                                           input int unsigned        n);
        logic signed [63:0] s;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_res_t           r;
        s     = acc >>> f;
        hi    = (64'sd1 <<< (n - 1)) - 64'sd1;
        lo    = -(64'sd1 <<< (n - 1));
        r.sat = 1'b0;
        r.val = 32'(s);
        if (s > hi) begin
            r.sat = 1'b1;
            r.val = 32'(hi);
        end else if (s < lo) begin
            r.sat = 1'b1;
            r.val = 32'(lo);
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_if.sv
// Handshake, control/status and read-port bundle between a neuron output stage and its host.
interface neuron_if
    import neuron_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned Q = Q_DEF
);
    logic                  st;
    logic [Q:0]            num_out;
    logic signed [2*N-1:0] acc_in;
    logic                  acc_valid;
    logic                  acc_ready;
    logic [Q-1:0]          rd_addr;
    logic signed [N-1:0]   rd_data;
    logic                  busy;
    logic                  done;
    logic                  sat_flag;
    logic [Q:0]            wr_count;

    modport master (
        output st, num_out, acc_in, acc_valid, rd_addr,
        input  acc_ready, rd_data, busy, done, sat_flag, wr_count
    );

    modport slave (
        input  st, num_out, acc_in, acc_valid, rd_addr,
        output acc_ready, rd_data, busy, done, sat_flag, wr_count
    );

endinterface

// File: rtl/neuron_output_stage_mem.sv
// Result memory: one write port, one registered read-before-write read port, array not reset.
module result_mem
    import neuron_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned Q = Q_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                we_i,
    input  logic [Q-1:0]        waddr_i,
    input  logic signed [N-1:0] wdata_i,
    input  logic [Q-1:0]        raddr_i,
    output logic signed [N-1:0] rdata_o
);

    logic signed [N-1:0] mem_q [2**Q];
    logic signed [N-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Same-edge write is not yet visible here, so a colliding read returns the old word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_output_stage.sv
// Rescales accumulator beats (>>> F, saturate to N bits) into result_mem and pulses done per batch.
// Define NEURON_RELU_EN to clamp negative results to zero before the write.
module neuron_output_stage
    import neuron_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned F = F_DEF,
    parameter int unsigned Q = Q_DEF
) (
    input  logic     clk,
    input  logic     rst,
    neuron_if.slave  bus
);

    state_e              state_q;
    logic [Q:0]          num_q;
    logic [Q:0]          wr_count_q;
    logic [Q:0]          wr_count_d;
    logic                sat_q;
    logic                done_q;
    logic                busy_q;
    logic                ready_q;

    logic                accept;
    sat_res_t            sr;
    logic signed [N-1:0] wr_data;
    logic                unused_hi;

    function automatic logic signed [N-1:0] out_fmt(input logic signed [N-1:0] v);
`ifdef NEURON_RELU_EN
        return v[N-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign accept     = bus.acc_valid & ready_q;
    assign sr         = sat_shift(64'(bus.acc_in), F, N);
    assign unused_hi  = ^sr.val[31:N];
    assign wr_data    = out_fmt(sr.val[N-1:0]);
    assign wr_count_d = wr_count_q + (Q+1)'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            num_q      <= '0;
            wr_count_q <= '0;
            sat_q      <= 1'b0;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.st) begin
                        num_q      <= bus.num_out;
                        wr_count_q <= '0;
                        sat_q      <= 1'b0;
                        if (bus.num_out == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                            ready_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        wr_count_q <= wr_count_d;
                        sat_q      <= sat_q | sr.sat;
                        // Outputs are registered, so the last beat is detected on the incremented count.
                        if (wr_count_d == num_q) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    result_mem #(
        .N(N),
        .Q(Q)
    ) u_mem (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (accept),
        .waddr_i (wr_count_q[Q-1:0]),
        .wdata_i (wr_data),
        .raddr_i (bus.rd_addr),
        .rdata_o (bus.rd_data)
    );

    assign bus.acc_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sat_flag  = sat_q;
    assign bus.wr_count  = wr_count_q;

endmodule

// File: tb/tb_neuron_output_stage.sv
// Directed bench: read-port data checked through a scoreboard queue, control/status checked inline.
module tb_neuron_output_stage;

    localparam int N = 16;
    localparam int F = 8;
    localparam int Q = 4;

`ifdef NEURON_RELU_EN
    localparam logic [15:0] E_MIN  = 16'h0000;
    localparam logic [15:0] E_M1P5 = 16'h0000;
`else
    localparam logic [15:0] E_MIN  = 16'h8000;
    localparam logic [15:0] E_M1P5 = 16'hFFFE;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    neuron_if #(.N(N), .Q(Q)) bus ();

    neuron_output_stage #(.N(N), .F(F), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [15:0] exp;
    } rd_exp_t;

    rd_exp_t sb_q[$];
    int      checks  = 0;
    int      errors  = 0;
    int      acc_cnt = 0;
    logic    rd_en   = 1'b0;
    logic    rd_pend = 1'b0;

    always @(posedge clk) begin
        rd_pend <= rd_en;
        if (!rst && bus.acc_valid && bus.acc_ready) acc_cnt++;
    end

    // Scoreboard monitor: one registered read result per issued read.
    always @(negedge clk) begin
        if (rd_pend) begin
            rd_exp_t e;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL rd_unexpected: rd_data=%h with no expected entry", bus.rd_data);
            end else begin
                e = sb_q.pop_front();
                if (bus.rd_data !== e.exp) begin
                    errors++;
                    $display("FAIL %s: rd_data=%h expected=%h", e.name, bus.rd_data, e.exp);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int n);
        bus.num_out = (Q+1)'(n);
        bus.st      = 1'b1;
        tick();
        bus.st      = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        bus.acc_in    = d;
        bus.acc_valid = 1'b1;
        tick();
        bus.acc_valid = 1'b0;
    endtask

    task automatic rd(input int a, input logic [15:0] e, input string nm);
        bus.rd_addr = (Q)'(a);
        rd_en       = 1'b1;
        sb_q.push_back('{name: nm, exp: e});
        tick();
        rd_en       = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  c0;
        bit  vpat [6];
        int  k;
        vpat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        bus.st = 1'b0; bus.num_out = '0; bus.acc_in = '0; bus.acc_valid = 1'b0; bus.rd_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.acc_ready), 0);
        chk("rst_busy",  32'(bus.busy), 0);
        chk("rst_done",  32'(bus.done), 0);
        chk("rst_sat",   32'(bus.sat_flag), 0);
        chk("rst_wrcnt", 32'(bus.wr_count), 0);
        chk("rst_rdata", 32'(bus.rd_data), 0);
        rst = 1'b0;
        tick();

        // Basic rescale
        start(3);
        chk("b_ready_after_st", 32'(bus.acc_ready), 1);
        chk("b_busy", 32'(bus.busy), 1);
        beat(32'h0000_0180);
        beat(32'h0000_0000);
        beat(32'h0000_7F00);
        chk("b_done", 32'(bus.done), 1);
        chk("b_ready_done", 32'(bus.acc_ready), 0);
        chk("b_wrcnt", 32'(bus.wr_count), 3);
        chk("b_sat", 32'(bus.sat_flag), 0);
        tick();
        chk("b_done_1cyc", 32'(bus.done), 0);
        rd(0, 16'h0001, "b_mem0");
        rd(1, 16'h0000, "b_mem1");
        rd(2, 16'h007F, "b_mem2");

        // Saturation and negatives
        start(3);
        beat(32'h0100_0000);
        beat(32'hF000_0000);
        beat(32'hFFFF_FE80);
        chk("s_done", 32'(bus.done), 1);
        chk("s_sat", 32'(bus.sat_flag), 1);
        tick();
        chk("s_sat_hold", 32'(bus.sat_flag), 1);
        rd(0, 16'h7FFF, "s_pos_sat");
        rd(1, E_MIN,    "s_neg_sat");
        rd(2, E_M1P5,   "s_floor");

        // Handshake stalls
        chk("h_ready_before", 32'(bus.acc_ready), 0);
        c0 = acc_cnt;
        start(4);
        k = 0;
        for (int i = 0; i < 6; i++) begin
            bus.acc_valid = vpat[i];
            if (vpat[i]) begin
                bus.acc_in = 32'h0A00 + 32'(k) * 32'h100;
                k++;
            end
            tick();
        end
        bus.acc_valid = 1'b0;
        chk("h_done", 32'(bus.done), 1);
        chk("h_accepts", 32'(acc_cnt - c0), 4);
        chk("h_ready_done", 32'(bus.acc_ready), 0);
        tick();
        chk("h_ready_after", 32'(bus.acc_ready), 0);
        for (int i = 0; i < 4; i++) rd(i, 16'(16'h0A + i), "h_mem");

        // num_out = 0
        c0 = acc_cnt;
        bus.acc_in = 32'h0000_0500;
        bus.acc_valid = 1'b1;
        start(0);
        chk("z_done", 32'(bus.done), 1);
        chk("z_ready", 32'(bus.acc_ready), 0);
        chk("z_busy", 32'(bus.busy), 0);
        tick();
        bus.acc_valid = 1'b0;
        chk("z_done_off", 32'(bus.done), 0);
        chk("z_no_writes", 32'(acc_cnt - c0), 0);
        chk("z_wrcnt", 32'(bus.wr_count), 0);

        // Full depth, with a second st ignored mid-batch
        start(16);
        for (int i = 0; i < 16; i++) begin
            bus.st      = (i == 5);
            bus.num_out = (i == 5) ? 5'd2 : 5'd0;
            beat(32'((i * 3 + 1) << 8));
        end
        bus.st = 1'b0;
        chk("f_done", 32'(bus.done), 1);
        chk("f_wrcnt", 32'(bus.wr_count), 16);
        tick();
        chk("f_wrcnt_hold", 32'(bus.wr_count), 16);
        for (int i = 0; i < 16; i++) rd(i, 16'(i * 3 + 1), "f_mem");

        // Reset mid-batch
        bus.rd_addr = '0;
        start(5);
        beat(32'h7FFF_FFFF);
        beat(32'h0000_0200);
        chk("r_sat_pre", 32'(bus.sat_flag), 1);
        chk("r_busy_pre", 32'(bus.busy), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("r_ready", 32'(bus.acc_ready), 0);
        chk("r_busy", 32'(bus.busy), 0);
        chk("r_done", 32'(bus.done), 0);
        chk("r_sat", 32'(bus.sat_flag), 0);
        chk("r_wrcnt", 32'(bus.wr_count), 0);
        chk("r_rdata", 32'(bus.rd_data), 0);
        #2;
        rst = 1'b0;
        tick();
        start(1);
        chk("r2_ready", 32'(bus.acc_ready), 1);
        beat(32'h0000_0500);
        chk("r2_done", 32'(bus.done), 1);
        chk("r2_wrcnt", 32'(bus.wr_count), 1);
        tick();
        rd(0, 16'h0005, "r2_mem0");

        // Read-before-write collision on address 2
        start(3);
        beat(32'h0000_1100);
        beat(32'h0000_2200);
        bus.acc_in    = 32'h0000_3300;
        bus.acc_valid = 1'b1;
        bus.rd_addr   = 4'd2;
        rd_en         = 1'b1;
        sb_q.push_back('{name: "rbw_old", exp: 16'h0007});
        tick();
        bus.acc_valid = 1'b0;
        rd_en         = 1'b0;
        chk("rbw_done", 32'(bus.done), 1);
        rd(2, 16'h0033, "rbw_new");
        rd(0, 16'h0011, "rbw_mem0");

        tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
